// File: rtl/icache_pkg.sv
// Shared encodings and the controller state type for the instruction cache.
package icache_pkg;

  // AXI read response encodings used on both the IFU and the memory side.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Refill bursts are always 32-bit INCR bursts.
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_AR,
    ST_REFILL,
    ST_RESP,
    ST_FLUSH
  } state_e;

endpackage : icache_pkg

// File: rtl/icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Synchronous write, combinational read, so it can later be replaced by
// SRAM macros with a matching wrapper.
module icache_array #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(SETS)-1:0]       index,
  input  logic [$clog2(LINE_WORDS)-1:0] word_sel,
  input  logic                          line_we,
  input  logic                          word_we,
  input  logic                          valid_clr,
  input  logic [TAG_W-1:0]              wtag,
  input  logic [31:0]                   wdata,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data
);

  localparam int IDX_W = $clog2(SETS);
  localparam int OFF_W = $clog2(LINE_WORDS);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*LINE_WORDS];

  logic [IDX_W+OFF_W-1:0] word_addr;
  assign word_addr = {index, word_sel};

  // Valid bits: cleared by reset and flush, set when a clean refill completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (valid_clr) begin
      valid_q[index] <= 1'b0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag and data writes.
  // NOTE: tag and data storage have no reset; the valid bits alone decide
  // whether their contents mean anything, which keeps them SRAM-compatible.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[index] <= wtag;
    end
    if (word_we) begin
      data_mem[word_addr] <= wdata;
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = data_mem[word_addr];

endmodule : icache_array

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Single outstanding fetch;
// hits answer one cycle after acceptance, misses refill a whole line with
// one INCR burst, and fence.i sweeps every valid bit one set per cycle.
module icache
  import icache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic        fence_i,
  output logic        flush_done
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int TAG_W   = 32 - IDX_W - OFF_W - 2;
  localparam int OFF_LSB = 2;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  state_e           state;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [OFF_W-1:0] req_offset;
  logic [IDX_W-1:0] sweep_idx;
  logic [OFF_W-1:0] beat_cnt;
  logic             refill_err;
  logic             fence_pend;

  logic [IDX_W-1:0] arr_index;
  logic [OFF_W-1:0] arr_word;
  logic             arr_line_we;
  logic             arr_word_we;
  logic             arr_valid_clr;
  logic             arr_valid;
  logic [TAG_W-1:0] arr_tag;
  logic [31:0]      arr_data;

  logic             hit;
  logic             last_word;
  logic             final_err;

  // Byte-within-word bits are irrelevant to a word-aligned fetch.
  logic unused_byte_bits;
  assign unused_byte_bits = ^s_araddr[1:0];

  assign m_araddr  = {req_tag, req_index, {OFF_W{1'b0}}, 2'b00};
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;

  // Array addressing and write strobes derived from the current state.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    arr_index     = req_index;
    arr_word      = req_offset;
    arr_line_we   = 1'b0;
    arr_word_we   = 1'b0;
    arr_valid_clr = 1'b0;
    last_word     = (beat_cnt == OFF_W'(LINE_WORDS - 1));
    // An error on any beat, or m_rlast before the final word, poisons the line.
    final_err     = refill_err || (m_rresp != RESP_OKAY) || !last_word;
    hit           = arr_valid && (arr_tag == req_tag);
    case (state)
      ST_FLUSH: begin
        arr_index     = sweep_idx;
        arr_valid_clr = 1'b1;
      end
      ST_REFILL: begin
        arr_word    = beat_cnt;
        arr_word_we = m_rvalid;
        if (m_rvalid && m_rlast) begin
          arr_line_we   = !final_err;
          arr_valid_clr = final_err;
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with registered handshake outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_FLUSH;
      sweep_idx  <= '0;
      beat_cnt   <= '0;
      refill_err <= 1'b0;
      fence_pend <= 1'b0;
      req_tag    <= '0;
      req_index  <= '0;
      req_offset <= '0;
      s_arready  <= 1'b0;
      s_rvalid   <= 1'b0;
      s_rresp    <= RESP_OKAY;
      s_rdata    <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      // A fence seen while busy is remembered and serviced from IDLE.
      if (fence_i && (state inside {ST_LOOKUP, ST_MISS_AR, ST_REFILL, ST_RESP})) begin
        fence_pend <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (fence_i || fence_pend) begin
            state      <= ST_FLUSH;
            sweep_idx  <= '0;
            fence_pend <= 1'b0;
            s_arready  <= 1'b0;
          end else if (s_arvalid) begin
            req_tag    <= s_araddr[31:TAG_LSB];
            req_index  <= s_araddr[TAG_LSB-1:IDX_LSB];
            req_offset <= s_araddr[IDX_LSB-1:OFF_LSB];
            s_arready  <= 1'b0;
            state      <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            s_rdata  <= arr_data;
            s_rresp  <= RESP_OKAY;
            s_rvalid <= 1'b1;
            state    <= ST_RESP;
          end else begin
            m_arvalid <= 1'b1;
            state     <= ST_MISS_AR;
          end
        end
        ST_MISS_AR: begin
          if (m_arready) begin
            m_arvalid  <= 1'b0;
            m_rready   <= 1'b1;
            beat_cnt   <= '0;
            refill_err <= 1'b0;
            state      <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (m_rvalid) begin
            if (beat_cnt == req_offset) begin
              s_rdata <= m_rdata;
            end
            if (!last_word) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (m_rresp != RESP_OKAY) begin
              refill_err <= 1'b1;
            end
            if (m_rlast) begin
              m_rready <= 1'b0;
              s_rvalid <= 1'b1;
              s_rresp  <= final_err ? RESP_SLVERR : RESP_OKAY;
              state    <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            // Do not advertise readiness when IDLE will go straight to FLUSH.
            s_arready <= !(fence_pend || fence_i);
            state     <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (sweep_idx == IDX_W'(SETS - 1)) begin
            flush_done <= 1'b1;
            s_arready  <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  icache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (arr_index),
    .word_sel  (arr_word),
    .line_we   (arr_line_we),
    .word_we   (arr_word_we),
    .valid_clr (arr_valid_clr),
    .wtag      (req_tag),
    .wdata     (m_rdata),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data)
  );

endmodule : icache

// File: tb/tb_icache.sv
// Directed bench for icache: the bench plays both the IFU and the memory.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_icache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rvalid;
  logic        m_rready;
  logic        fence_i;
  logic        flush_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  icache #(.SETS(16), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_araddr   (s_araddr),
    .s_arvalid  (s_arvalid),
    .s_arready  (s_arready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .m_araddr   (m_araddr),
    .m_arlen    (m_arlen),
    .m_arsize   (m_arsize),
    .m_arburst  (m_arburst),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rlast    (m_rlast),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .fence_i    (fence_i),
    .flush_done (flush_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One fetch: request, act as memory if a refill appears, collect the response.
  // fill_base+k is returned on beat k; err_beat/fence_beat (-1 = none) select the
  // beat that carries SLVERR or that is accompanied by a fence_i pulse.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] fill_base,
                       input int err_beat, input int fence_beat, input int ar_delay,
                       input int hold, output logic [31:0] rdata, output logic [1:0] rresp,
                       output logic [31:0] araddr, output int lat, output bit missed);
    int wait_cnt = 0;
    int beat     = 0;
    int ar_wait  = 0;
    bit phase    = 1'b0;
    missed = 1'b0;
    araddr = '0;
    @(negedge clk);
    s_araddr  = addr;
    s_arvalid = 1'b1;
    while (!s_arready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("accept_timeout", 64'(wait_cnt >= 50), 64'd0);
    @(negedge clk);
    s_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 100) begin
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rlast   = 1'b0;
      m_rresp   = 2'b00;
      fence_i   = 1'b0;
      if (!phase && m_arvalid) begin
        if (missed) check("araddr_stable", 64'(m_araddr), 64'(araddr));
        else araddr = m_araddr;
        missed = 1'b1;
        if (ar_wait == ar_delay) begin
          m_arready = 1'b1;
          phase     = 1'b1;
        end
        ar_wait++;
      end else if (phase && m_rready) begin
        m_rvalid = 1'b1;
        m_rdata  = fill_base + 32'(beat);
        m_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
        m_rlast  = (beat == 3);
        fence_i  = (beat == fence_beat);
        beat++;
      end
      @(negedge clk);
      lat++;
    end
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    m_rresp   = 2'b00;
    fence_i   = 1'b0;
    check("resp_timeout", 64'(lat >= 100), 64'd0);
    rdata = s_rdata;
    rresp = s_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_hold", {s_rvalid, s_arready, s_rresp, s_rdata}, {1'b1, 1'b0, rresp, rdata});
    end
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    check("rvalid_drop", 64'(s_rvalid), 64'd0);
  endtask

  // Counts falling edges until flush_done, then confirms it is a single pulse.
  task automatic expect_flush(input string tag, input int exp_cycles);
    int n = 0;
    while (!flush_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
    check({tag, "_arready"}, 64'(s_arready), 64'd1);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(flush_done), 64'd0);
  endtask

  logic [31:0] rd, ara;
  logic [1:0]  rr;
  int          lat;
  bit          miss;

  initial begin
    reset     = 1'b1;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    m_rlast   = 1'b0;
    m_rvalid  = 1'b0;
    fence_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {s_arready, s_rvalid, m_arvalid, m_rready, flush_done, s_rresp, s_rdata},
          64'd0);
    check("arlen", 64'(m_arlen), 64'd3);
    check("arsize_burst", {m_arsize, m_arburst}, {3'b010, 2'b01});
    reset = 1'b0;
    // 16 sweep cycles after reset release; arready and flush_done appear together.
    expect_flush("reset_flush", 16);

    // Cold miss.
    fetch(32'h8000_0008, 32'hA0, -1, -1, 0, 0, rd, rr, ara, lat, miss);
    check("cold_miss", 64'(miss), 64'd1);
    check("cold_araddr", 64'(ara), 64'h8000_0000);
    check("cold_rdata", 64'(rd), 64'hA2);
    check("cold_rresp", 64'(rr), 64'd0);

    // Hit after fill: acceptance cycle plus one lookup cycle.
    fetch(32'h8000_000C, 32'h0, -1, -1, 0, 0, rd, rr, ara, lat, miss);
    check("hit_miss", 64'(miss), 64'd0);
    check("hit_latency", 64'(lat), 64'd2);
    check("hit_rdata", 64'(rd), 64'hA3);

    // Conflict eviction on index 0, memory slow to take the address.
    fetch(32'h8000_0100, 32'hB0, -1, -1, 2, 0, rd, rr, ara, lat, miss);
    check("evict_miss", 64'(miss), 64'd1);
    check("evict_araddr", 64'(ara), 64'h8000_0100);
    check("evict_rdata", 64'(rd), 64'hB0);
    fetch(32'h8000_0000, 32'hA0, -1, -1, 0, 0, rd, rr, ara, lat, miss);
    check("refetch_miss", 64'(miss), 64'd1);
    check("refetch_rdata", 64'(rd), 64'hA0);
    fetch(32'h8000_0004, 32'h0, -1, -1, 0, 0, rd, rr, ara, lat, miss);
    check("refetch_hit", {miss, rd}, {1'b0, 32'hA1});

    // Error refill on index 1: line stays invalid.
    fetch(32'h8000_0014, 32'hC0, 1, -1, 0, 0, rd, rr, ara, lat, miss);
    check("err_miss", 64'(miss), 64'd1);
    check("err_rresp", 64'(rr), 64'd2);
    fetch(32'h8000_0018, 32'hC0, -1, -1, 0, 0, rd, rr, ara, lat, miss);
    check("err_remiss", 64'(miss), 64'd1);
    check("err_araddr", 64'(ara), 64'h8000_0010);
    check("err_reread", {rr, rd}, {2'b00, 32'hC2});
    fetch(32'h8000_0014, 32'h0, -1, -1, 0, 0, rd, rr, ara, lat, miss);
    check("err_then_hit", {miss, rd}, {1'b0, 32'hC1});

    // fence_i during refill: response first, then one IDLE cycle and 16 sweeps.
    fetch(32'h8000_0028, 32'hD0, -1, 1, 0, 0, rd, rr, ara, lat, miss);
    check("fence_refill", {miss, rr, rd}, {1'b1, 2'b00, 32'hD2});
    expect_flush("fence_flush", 17);
    fetch(32'h8000_0008, 32'hA0, -1, -1, 0, 0, rd, rr, ara, lat, miss);
    check("post_flush_miss", 64'(miss), 64'd1);
    check("post_flush_rdata", 64'(rd), 64'hA2);

    // Backpressure on a hit: response held for 5 cycles.
    fetch(32'h8000_000C, 32'h0, -1, -1, 0, 5, rd, rr, ara, lat, miss);
    check("bp_rdata", {miss, rr, rd}, {1'b0, 2'b00, 32'hA3});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule : tb_icache

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU's AXI read channel and the instruction memory bus.
- Accepts single-beat 32-bit fetch requests. Hits return in one cycle; misses refill a whole line with one AXI INCR burst.
- Implements fence.i by sweeping all valid bits, then pulsing flush_done back to the IFU.

Parameters:
- SETS, 16, number of lines; power of two, ≥2.
- LINE_WORDS, 4, 32-bit words per line; power of two, ≥2.
- Tag width = 32 - log2(SETS) - log2(LINE_WORDS) - 2. Derived, not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_araddr  in  32  fetch address (word-aligned)
- s_arvalid  in  1  fetch request valid
- s_arready  out  1  cache can accept a request
- s_rdata  out  32  instruction word
- s_rresp  out  2  00 OKAY, 10 SLVERR
- s_rvalid  out  1  response valid
- s_rready  in  1  IFU accepts response
- m_araddr  out  32  line-aligned refill address
- m_arlen  out  8  constant LINE_WORDS-1
- m_arsize  out  3  constant 3'b010
- m_arburst  out  2  constant 2'b01 (INCR)
- m_arvalid  out  1  refill request valid
- m_arready  in  1  memory accepts request
- m_rdata  in  32  refill beat
- m_rresp  in  2  beat response
- m_rlast  in  1  last beat
- m_rvalid  in  1  beat valid
- m_rready  out  1  cache accepts beat
- fence_i  in  1  level or pulse; starts a flush
- flush_done  out  1  one-cycle pulse when the flush completes

Behaviour:
- Reset values: s_arready=0, s_rvalid=0, s_rresp=0, s_rdata=0, m_arvalid=0, m_rready=0, flush_done=0. All valid bits are cleared. State is FLUSH with sweep index 0, so the cache is usable SETS+1 cycles after reset deasserts.
- Address split: [1:0] byte (ignored); next log2(LINE_WORDS) bits = offset; next log2(SETS) bits = index; the rest = tag.
- IDLE:
  - s_arready=1.
  - fence_i=1 → FLUSH. This takes priority over a simultaneous s_arvalid, which is not accepted.
  - Otherwise, on s_arvalid&s_arready, latch the address → LOOKUP.
- LOOKUP: compare the stored tag and valid bit at the index.
  - Hit → RESP with s_rdata = line word; one-cycle hit latency from acceptance to s_rvalid.
  - Miss → MISS_AR.
- MISS_AR:
  - m_arvalid=1, m_araddr = {tag, index, 0 offset, 2'b00}.
  - m_arvalid and m_araddr stay stable until m_arready → REFILL.
- REFILL:
  - m_rready=1. Each beat is written to word = beat counter, which starts at 0.
  - The requested word is also captured into the response register as its beat arrives.
  - Any m_rresp≠00 sets a sticky error flag.
  - On the m_rlast beat:
    - If no error: set valid, write the tag.
    - If error: leave the line invalid, s_rresp=10.
    - Then → RESP.
  - The beat counter saturates at LINE_WORDS-1. An early m_rlast ends the refill with an error.
- RESP:
  - s_rvalid=1; s_rdata and s_rresp are held stable until s_rready.
  - On the handshake, s_rvalid→0 and state → IDLE.
  - The IFU is allowed to discard the data (epoch mismatch); the cache does not care.
- FLUSH:
  - Clear one set per cycle, index 0..SETS-1.
  - After the last set, pulse flush_done for one cycle → IDLE.
  - fence_i during FLUSH is ignored; one flush covers it.
- fence_i arriving in LOOKUP, MISS_AR, REFILL or RESP is latched as pending and serviced on the next IDLE.
  - An in-flight refill completes and fills normally; the flush then invalidates it.
- The AXI burst is never abandoned mid-transfer. All beats are consumed even when the result will be discarded.
- Reset asserted mid-refill returns to the reset state. Beats still in flight from memory are the memory model's responsibility; the bench resets both.
- Only one request is outstanding at a time. s_arready=0 everywhere except IDLE.

Decomposition:
- Shared package: the s_rresp/m_rresp encodings (OKAY=2'b00, SLVERR=2'b10), AXI size/burst constants, and the state enumeration.
- One natural sub-module, icache_array: tag+valid storage and data storage.
  - Synchronous write, combinational read.
  - Ports: index, word select, line write enable, word write enable, valid clear.
  - Swappable for SRAM macros later.

Test Plan:
- Cold miss: after reset+flush, read 0x8000_0008 → one burst, m_araddr=0x8000_0000, arlen=3; beats 0xA0..0xA3 → s_rdata=0xA2, s_rresp=00.
- Hit after fill: read 0x8000_000C → no m_arvalid; s_rvalid exactly 2 cycles after s_arvalid is accepted, s_rdata=0xA3.
- Conflict eviction: read 0x8000_0100 (same index 0, SETS=16) → refill; then 0x8000_0000 misses again.
- Error refill: beat 1 has m_rresp=10 → s_rresp=10; an immediate re-read of the same line misses and refetches.
- fence_i during REFILL: refill completes and the response is delivered; then FLUSH takes 16 cycles; flush_done is high for exactly 1 cycle; the next read of 0x8000_0008 misses.
- Backpressure: hold s_rready=0 for 5 cycles in RESP → s_rvalid and s_rdata stay stable, s_arready=0 throughout.
